// File: rtl/mu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mu_pkg
// Purpose  : Shared definitions for the micro-sequencer: FSM state enum,
//            Step output encoding and the default program address width.
// Config   : MU_SINGLE_STEP_EN adds the PAUSE state to the enum.
// Revision : 1.0 - initial release
// ============================================================================
package mu_pkg;

  localparam int unsigned C_ADDR_W_DEFAULT = 8;

  // Step output encoding (one code per micro-step)
  localparam logic [1:0] C_STEP_FETCH     = 2'b00;
  localparam logic [1:0] C_STEP_DECODE    = 2'b01;
  localparam logic [1:0] C_STEP_EXECUTE   = 2'b10;
  localparam logic [1:0] C_STEP_WRITEBACK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
`ifdef MU_SINGLE_STEP_EN
    ST_WRITEBACK = 3'd4,
    ST_PAUSE     = 3'd5
`else
    ST_WRITEBACK = 3'd4
`endif
  } mu_state_e;

endpackage : mu_pkg
`default_nettype wire

// File: rtl/mu_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : mu_pc_reg
// Purpose  : Program address register for the micro-sequencer. Holds the
//            current address and the next-address value chosen in EXECUTE
//            (branch target or current+1 with wrap at LAST_ADDR).
// Ports    : clk, rst_n          - clock, async active-low reset
//            i_load, i_load_addr - load a start address (takes priority)
//            i_latch             - capture next address (EXECUTE cycle)
//            i_branch, i_branch_addr - branch select and target
//            i_advance           - move next address into PC (WRITEBACK exit)
//            o_pc                - current program address
// Revision : 1.0 - initial release
// ============================================================================
module mu_pc_reg #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LAST_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_latch,
  input  logic              i_branch,
  input  logic [ADDR_W-1:0] i_branch_addr,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] C_LAST = LAST_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] C_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [ADDR_W-1:0] w_inc;

  // LAST_ADDR may be below the natural 2**ADDR_W-1 wrap point
  assign w_inc = (pc_q == C_LAST) ? '0 : (pc_q + C_ONE);

  always_comb begin
    pc_d  = pc_q;
    nxt_d = nxt_q;
    if (i_load) begin
      pc_d = i_load_addr;
    end else if (i_advance) begin
      pc_d = nxt_q;
    end
    if (i_latch) begin
      nxt_d = i_branch ? i_branch_addr : w_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      nxt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      nxt_q <= nxt_d;
    end
  end

  assign o_pc = pc_q;

endmodule : mu_pc_reg
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Purpose  : Four-step instruction sequencer (FETCH, DECODE, EXECUTE,
//            WRITEBACK) with fetch stall, branch select, halt at the next
//            instruction boundary and an End pulse on halt completion.
// Ports    : Clock, Reset_n      - rising-edge clock, async active-low reset
//            Start, StartAddr    - begin execution at StartAddr (IDLE only)
//            MemReady            - instruction memory accepted the fetch
//            BranchTaken, BranchAddr - branch select/target, sampled in EXECUTE
//            Halt                - level request to stop after current instr
//            StepGo              - (MU_SINGLE_STEP_EN only) leave PAUSE
//            PcAddr, Step, FetchReq, Busy, End - status outputs
// Config   : MU_SINGLE_STEP_EN - adds StepGo input and a PAUSE state entered
//            after every WRITEBACK.
// Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer
  import mu_pkg::*;
#(
  parameter int unsigned ADDR_W    = C_ADDR_W_DEFAULT,
  parameter int unsigned LAST_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic              MemReady,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchAddr,
  input  logic              Halt,
`ifdef MU_SINGLE_STEP_EN
  input  logic              StepGo,
`endif
  output logic [ADDR_W-1:0] PcAddr,
  output logic [1:0]        Step,
  output logic              FetchReq,
  output logic              Busy,
  output logic              End
);

  mu_state_e state_q, state_d;
  logic      halt_pend_q, halt_pend_d;
  logic      end_q, end_d;

  logic      w_load;
  logic      w_latch;
  logic      w_advance;
  logic      w_stop;

  // A halt seen on the boundary cycle itself counts as pending
  assign w_stop = halt_pend_q | Halt;

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    end_d       = 1'b0;
    w_load      = 1'b0;
    w_latch     = 1'b0;
    w_advance   = 1'b0;

    if ((state_q != ST_IDLE) && Halt) begin
      halt_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          w_load      = 1'b1;
          state_d     = ST_FETCH;
          // Start wins over Halt; the halt takes effect after one instruction
          halt_pend_d = Halt;
        end
      end
      ST_FETCH: begin
        if (MemReady) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        w_latch = 1'b1;
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        w_advance = 1'b1;
        if (w_stop) begin
          state_d     = ST_IDLE;
          end_d       = 1'b1;
          halt_pend_d = 1'b0;
        end else begin
`ifdef MU_SINGLE_STEP_EN
          state_d = ST_PAUSE;
`else
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef MU_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (w_stop) begin
          state_d     = ST_IDLE;
          end_d       = 1'b1;
          halt_pend_d = 1'b0;
        end else if (StepGo) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        halt_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      halt_pend_q <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      end_q       <= end_d;
    end
  end

  mu_pc_reg #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_pc_reg (
    .clk           (Clock),
    .rst_n         (Reset_n),
    .i_load        (w_load),
    .i_load_addr   (StartAddr),
    .i_latch       (w_latch),
    .i_branch      (BranchTaken),
    .i_branch_addr (BranchAddr),
    .i_advance     (w_advance),
    .o_pc          (PcAddr)
  );

  always_comb begin
    Step = C_STEP_FETCH;
    unique case (state_q)
      ST_DECODE:    Step = C_STEP_DECODE;
      ST_EXECUTE:   Step = C_STEP_EXECUTE;
      ST_WRITEBACK: Step = C_STEP_WRITEBACK;
`ifdef MU_SINGLE_STEP_EN
      ST_PAUSE:     Step = C_STEP_WRITEBACK;
`endif
      default:      Step = C_STEP_FETCH;
    endcase
  end

  assign FetchReq = (state_q == ST_FETCH);
  assign Busy     = (state_q != ST_IDLE);
  assign End      = end_q;

endmodule : micro_sequencer
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_sequencer
// Purpose  : Self-checking bench for micro_sequencer (default ADDR_W=8
//            instance plus an ADDR_W=4 instance for address wrap).
// Config   : MU_SINGLE_STEP_EN selects the single-step scenario set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  typedef struct packed {
    logic [1:0] step;
    logic [7:0] pc;
    logic       fr;
    logic       busy;
    logic       en;
  } obs_t;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       Start, MemReady, BranchTaken, Halt, StepGo;
  logic [7:0] StartAddr, BranchAddr;
  wire  [7:0] w_pc;
  wire  [1:0] w_step;
  wire        w_fr, w_busy, w_end;

  logic       Start4, Halt4;
  logic [3:0] StartAddr4;
  logic [3:0] BranchAddr4 = 4'h0;
  logic       BranchTaken4 = 1'b0;
  wire  [3:0] w_pc4;
  wire  [1:0] w_step4;
  wire        w_fr4, w_busy4, w_end4;

  obs_t exp_q[$];
  obs_t got, want;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clock = ~Clock;

  micro_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .MemReady(MemReady), .BranchTaken(BranchTaken), .BranchAddr(BranchAddr),
    .Halt(Halt),
`ifdef MU_SINGLE_STEP_EN
    .StepGo(StepGo),
`endif
    .PcAddr(w_pc), .Step(w_step), .FetchReq(w_fr), .Busy(w_busy), .End(w_end)
  );

  micro_sequencer #(.ADDR_W(4)) dut4 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start4), .StartAddr(StartAddr4),
    .MemReady(MemReady), .BranchTaken(BranchTaken4), .BranchAddr(BranchAddr4),
    .Halt(Halt4),
`ifdef MU_SINGLE_STEP_EN
    .StepGo(StepGo),
`endif
    .PcAddr(w_pc4), .Step(w_step4), .FetchReq(w_fr4), .Busy(w_busy4), .End(w_end4)
  );

  wire obs_t obs_m = {w_step, w_pc, w_fr, w_busy, w_end};
  wire obs_t obs_4 = {w_step4, 4'h0, w_pc4, w_fr4, w_busy4, w_end4};

  function automatic obs_t mk(logic [1:0] s, logic [7:0] p, logic f, logic b, logic e);
    obs_t o;
    o.step = s; o.pc = p; o.fr = f; o.busy = b; o.en = e;
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; MemReady = 1'b0; BranchTaken = 1'b0;
    Halt = 1'b0; StepGo = 1'b0; StartAddr = 8'h00; BranchAddr = 8'h00;
    Start4 = 1'b0; Halt4 = 1'b0; StartAddr4 = 4'h0;
    #3;
    exp_q.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_state got=%p want=%p", got, want); end
    exp_q.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
    got = obs_4; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_state4 got=%p want=%p", got, want); end
    // Start while reset is held must not launch anything
    Start = 1'b1; StartAddr = 8'h77;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL reset_hold k=%0d got=%p want=%p", k, got, want); end
    end
    Start = 1'b0; Reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL reset_wait k=%0d got=%p want=%p", k, got, want); end
    end
  endtask

  // Free-running sequence from address 5, halted after the third instruction
  task automatic test_sequence();
    MemReady = 1'b1; Start = 1'b1; StartAddr = 8'd5;
    exp_q.push_back(mk(2'b00, 8'd5, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL seq_start got=%p want=%p", got, want); end
    Start = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      int n = c + 1;
      Halt = (c == 9);
      if (n < 12) exp_q.push_back(mk(2'(n % 4), 8'(5 + n / 4), (n % 4) == 0, 1'b1, 1'b0));
      else        exp_q.push_back(mk(2'b00, 8'd8, 1'b0, 1'b0, n == 12));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL seq n=%0d got=%p want=%p", n, got, want); end
    end
    Halt = 1'b0;
  endtask

  // Three stalled FETCH cycles, then normal progression and halt
  task automatic test_stall();
    MemReady = 1'b0; Start = 1'b1; StartAddr = 8'h10;
    exp_q.push_back(mk(2'b00, 8'h10, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL stall_start got=%p want=%p", got, want); end
    Start = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      int n = c + 1;
      MemReady = (c >= 3);
      Halt = (c == 4);
      if (n <= 3)      exp_q.push_back(mk(2'b00, 8'h10, 1'b1, 1'b1, 1'b0));
      else if (n <= 6) exp_q.push_back(mk(2'(n - 3), 8'h10, 1'b0, 1'b1, 1'b0));
      else             exp_q.push_back(mk(2'b00, 8'h11, 1'b0, 1'b0, n == 7));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL stall n=%0d got=%p want=%p", n, got, want); end
    end
    Halt = 1'b0; MemReady = 1'b1;
  endtask

  // Branch taken only counts in EXECUTE; decoy targets elsewhere are ignored
  task automatic test_branch();
    MemReady = 1'b1; Start = 1'b1; StartAddr = 8'h07;
    exp_q.push_back(mk(2'b00, 8'h07, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL br_start got=%p want=%p", got, want); end
    Start = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      int n = c + 1;
      BranchTaken = (c <= 3);
      BranchAddr  = (c == 2) ? 8'h20 : 8'h55;
      Halt = (c == 6);
      if (n <= 3)      exp_q.push_back(mk(2'(n), 8'h07, 1'b0, 1'b1, 1'b0));
      else if (n <= 7) exp_q.push_back(mk(2'(n - 4), 8'h20, n == 4, 1'b1, 1'b0));
      else             exp_q.push_back(mk(2'b00, 8'h21, 1'b0, 1'b0, n == 8));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL branch n=%0d got=%p want=%p", n, got, want); end
    end
    BranchTaken = 1'b0; Halt = 1'b0;
  endtask

  // Start+Halt together, Start ignored while busy, back-to-back restart
  task automatic test_start_halt();
    MemReady = 1'b1; Start = 1'b1; Halt = 1'b1; StartAddr = 8'h30;
    exp_q.push_back(mk(2'b00, 8'h30, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL sh_start got=%p want=%p", got, want); end
    for (int c = 0; c <= 10; c++) begin
      int n = c + 1;
      Start = (c == 1) || (c == 5);
      StartAddr = (c == 5) ? 8'h40 : 8'h99;
      Halt = (c == 0) || (c == 7);
      if (n <= 3)      exp_q.push_back(mk(2'(n), 8'h30, 1'b0, 1'b1, 1'b0));
      else if (n <= 5) exp_q.push_back(mk(2'b00, 8'h31, 1'b0, 1'b0, n == 4));
      else if (n <= 9) exp_q.push_back(mk(2'(n - 6), 8'h40, n == 6, 1'b1, 1'b0));
      else             exp_q.push_back(mk(2'b00, 8'h41, 1'b0, 1'b0, n == 10));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL start_halt n=%0d got=%p want=%p", n, got, want); end
    end
    Start = 1'b0; Halt = 1'b0;
  endtask

  // Reset during a FETCH stall with a halt pending, then a clean restart
  task automatic test_reset_stall();
    MemReady = 1'b0; Start = 1'b1; StartAddr = 8'h12;
    exp_q.push_back(mk(2'b00, 8'h12, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL rs_start got=%p want=%p", got, want); end
    Start = 1'b0; Halt = 1'b1;
    @(posedge Clock); #1;
    Halt = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    exp_q.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL rs_async got=%p want=%p", got, want); end
    for (int k = 0; k < 3; k++) begin
      if (k == 1) Reset_n = 1'b1;
      exp_q.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL rs_idle k=%0d got=%p want=%p", k, got, want); end
    end
    MemReady = 1'b1; Start = 1'b1; StartAddr = 8'h03;
    exp_q.push_back(mk(2'b00, 8'h03, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL rs_restart got=%p want=%p", got, want); end
    Start = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      int n = c + 1;
      Halt = (c == 5);
      if (n < 8) exp_q.push_back(mk(2'(n % 4), 8'(3 + n / 4), (n % 4) == 0, 1'b1, 1'b0));
      else       exp_q.push_back(mk(2'b00, 8'h05, 1'b0, 1'b0, n == 8));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL rs_run n=%0d got=%p want=%p", n, got, want); end
    end
    Halt = 1'b0;
  endtask

  // ADDR_W=4 instance: 15 wraps to 0, halt raised in DECODE
  task automatic test_wrap();
    MemReady = 1'b1; Start4 = 1'b1; StartAddr4 = 4'd15;
    exp_q.push_back(mk(2'b00, 8'd15, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_4; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL wrap_start got=%p want=%p", got, want); end
    Start4 = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      int n = c + 1;
      Halt4 = (c == 5);
      if (n < 8) exp_q.push_back(mk(2'(n % 4), (n < 4) ? 8'd15 : 8'd0, (n % 4) == 0, 1'b1, 1'b0));
      else       exp_q.push_back(mk(2'b00, 8'd1, 1'b0, 1'b0, n == 8));
      @(posedge Clock); #1;
      got = obs_4; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL wrap n=%0d got=%p want=%p", n, got, want); end
    end
    Halt4 = 1'b0;
  endtask

`ifdef MU_SINGLE_STEP_EN
  // PAUSE holds until StepGo; Halt in PAUSE beats StepGo and ends with End
  task automatic test_single_step();
    MemReady = 1'b1; StepGo = 1'b0; Start = 1'b1; StartAddr = 8'h50;
    exp_q.push_back(mk(2'b00, 8'h50, 1'b1, 1'b1, 1'b0));
    @(posedge Clock); #1;
    got = obs_m; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL ss_start got=%p want=%p", got, want); end
    Start = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      int n = c + 1;
      StepGo = (c == 6) || (c == 12);
      Halt = (c == 12);
      if (n <= 3)       exp_q.push_back(mk(2'(n), 8'h50, 1'b0, 1'b1, 1'b0));
      else if (n <= 6)  exp_q.push_back(mk(2'b11, 8'h51, 1'b0, 1'b1, 1'b0));
      else if (n <= 10) exp_q.push_back(mk(2'(n - 7), 8'h51, n == 7, 1'b1, 1'b0));
      else if (n <= 12) exp_q.push_back(mk(2'b11, 8'h52, 1'b0, 1'b1, 1'b0));
      else              exp_q.push_back(mk(2'b00, 8'h52, 1'b0, 1'b0, n == 13));
      @(posedge Clock); #1;
      got = obs_m; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL single_step n=%0d got=%p want=%p", n, got, want); end
    end
    StepGo = 1'b0; Halt = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef MU_SINGLE_STEP_EN
    test_single_step();
`else
    test_sequence();
    test_stall();
    test_branch();
    test_start_halt();
    test_reset_stall();
    test_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_micro_sequencer
`default_nettype wire
